// File: rtl/video_ctrl_wb.sv
// Wishbone control block for the HDMI video top: shadowed pattern/colour registers committed on vsync,
// plus a frame counter and frame interrupt. Optional auto-cycle of pattern mode under VIDEO_CTRL_AUTOCYCLE_EN.
module video_ctrl_wb #(
    parameter logic [1:0]  RESET_MODE   = 2'd0,
    parameter logic [23:0] RESET_COLOR  = 24'h00FF00,
    parameter bit          VS_POL       = 1'b1,
    parameter int          CYCLE_FRAMES = 60
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [1:0]  I_wb_adr,
    input  logic [31:0] I_wb_dat,
    input  logic [3:0]  I_wb_sel,
    input  logic        I_wb_we,
    input  logic        I_wb_stb,
    input  logic        I_wb_cyc,
    output logic [31:0] O_wb_dat,
    output logic        O_wb_ack,
    input  logic        I_vs,
    output logic [1:0]  O_pattern_mode,
    output logic [7:0]  O_single_r,
    output logic [7:0]  O_single_g,
    output logic [7:0]  O_single_b,
    output logic        O_irq
);

    localparam logic [1:0] ADR_CTRL   = 2'd0;
    localparam logic [1:0] ADR_COLOR  = 2'd1;
    localparam logic [1:0] ADR_STATUS = 2'd2;
    localparam logic [1:0] ADR_IRQ    = 2'd3;

    logic        r_ack;
    logic [31:0] r_wb_dat;
    logic        r_vs_s1, r_vs_s2, r_vs_s3;
    logic [1:0]  r_shadow_mode, r_live_mode;
    logic [23:0] r_shadow_color, r_live_color;
    logic        r_pending;
    logic [15:0] r_frame_cnt;
    logic        r_irq_sts, r_irq_en, r_irq;
    logic        r_auto_en;

    logic        w_req, w_wr, w_rd, w_tick;
    logic        w_wr_ctrl, w_wr_color, w_wr_irq, w_shadow_wr;
    logic        w_auto_step;
    logic [1:0]  w_auto_mode;
    logic [31:0] w_rdata;

    // A held strobe must not re-trigger while the previous ack is out.
    assign w_req       = I_wb_cyc & I_wb_stb & ~r_ack;
    assign w_wr        = w_req & I_wb_we;
    assign w_rd        = w_req & ~I_wb_we;
    assign w_wr_ctrl   = w_wr & (I_wb_adr == ADR_CTRL);
    assign w_wr_color  = w_wr & (I_wb_adr == ADR_COLOR);
    assign w_wr_irq    = w_wr & (I_wb_adr == ADR_IRQ);
    assign w_shadow_wr = (w_wr_ctrl | w_wr_color) & (|I_wb_sel);

    // Tick marks the end of the sync pulse, i.e. the start of the next frame's blanking.
    assign w_tick = VS_POL ? (r_vs_s3 & ~r_vs_s2) : (~r_vs_s3 & r_vs_s2);

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_vs_s1 <= ~VS_POL;
            r_vs_s2 <= ~VS_POL;
            r_vs_s3 <= ~VS_POL;
        end else begin
            r_vs_s1 <= I_vs;
            r_vs_s2 <= r_vs_s1;
            r_vs_s3 <= r_vs_s2;
        end
    end

`ifdef VIDEO_CTRL_AUTOCYCLE_EN
    localparam int STEP_W = $clog2(CYCLE_FRAMES + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CYCLE_FRAMES - 1);

    logic [STEP_W-1:0] r_step_cnt;

    // A pending CPU commit on the same tick takes priority over the automatic step.
    assign w_auto_step = w_tick & ~r_pending & r_auto_en & (r_step_cnt == STEP_LAST);
    assign w_auto_mode = r_live_mode + 2'd1;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_step_cnt <= '0;
        end else if (!r_auto_en) begin
            r_step_cnt <= '0;
        end else if (w_tick) begin
            if (r_pending || w_auto_step) begin
                r_step_cnt <= '0;
            end else begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_auto_step  = 1'b0;
    assign w_auto_mode  = 2'd0;
    assign w_unused_cfg = &{1'b0, CYCLE_FRAMES[0]};
`endif

    logic w_unused_dat;
    assign w_unused_dat = &{1'b0, I_wb_dat[31:24]};

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_shadow_mode  <= RESET_MODE;
            r_shadow_color <= RESET_COLOR;
            r_auto_en      <= 1'b0;
        end else begin
            // An auto step keeps shadow in sync, but a CPU write in the same cycle wins.
            if (w_auto_step) begin
                r_shadow_mode <= w_auto_mode;
            end
            if (w_wr_ctrl && I_wb_sel[0]) begin
                r_shadow_mode <= I_wb_dat[1:0];
`ifdef VIDEO_CTRL_AUTOCYCLE_EN
                r_auto_en     <= I_wb_dat[4];
`endif
            end
            if (w_wr_color) begin
                if (I_wb_sel[0]) r_shadow_color[7:0]   <= I_wb_dat[7:0];
                if (I_wb_sel[1]) r_shadow_color[15:8]  <= I_wb_dat[15:8];
                if (I_wb_sel[2]) r_shadow_color[23:16] <= I_wb_dat[23:16];
            end
        end
    end

    // Live values only move on a frame tick, so the picture never changes mid-frame.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_live_mode  <= RESET_MODE;
            r_live_color <= RESET_COLOR;
        end else if (w_tick && r_pending) begin
            r_live_mode  <= r_shadow_mode;
            r_live_color <= r_shadow_color;
        end else if (w_auto_step) begin
            r_live_mode  <= w_auto_mode;
        end
    end

    // A write on the tick cycle re-arms pending after the tick committed the older shadow.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_pending <= 1'b0;
        end else if (w_shadow_wr) begin
            r_pending <= 1'b1;
        end else if (w_tick) begin
            r_pending <= 1'b0;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_frame_cnt <= 16'd0;
        end else if (w_tick) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_irq_sts <= 1'b0;
            r_irq_en  <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_tick) begin
                r_irq_sts <= 1'b1;
            end else if (w_wr_irq && I_wb_sel[0] && I_wb_dat[0]) begin
                r_irq_sts <= 1'b0;
            end
            if (w_wr_irq && I_wb_sel[1]) begin
                r_irq_en <= I_wb_dat[8];
            end
            r_irq <= r_irq_sts & r_irq_en;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (I_wb_adr)
            ADR_CTRL:   w_rdata = {27'd0, r_auto_en, 2'd0, r_shadow_mode};
            ADR_COLOR:  w_rdata = {8'd0, r_shadow_color};
            ADR_STATUS: w_rdata = {13'd0, r_live_mode, r_pending, r_frame_cnt};
            ADR_IRQ:    w_rdata = {23'd0, r_irq_en, 7'd0, r_irq_sts};
            default:    w_rdata = 32'd0;
        endcase
    end

    // Read data is presented only alongside ack; it is zero at all other times.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_ack    <= 1'b0;
            r_wb_dat <= 32'd0;
        end else begin
            r_ack    <= w_req;
            r_wb_dat <= w_rd ? w_rdata : 32'd0;
        end
    end

    assign O_wb_ack       = r_ack;
    assign O_wb_dat       = r_wb_dat;
    assign O_pattern_mode = r_live_mode;
    assign O_single_r     = r_live_color[23:16];
    assign O_single_g     = r_live_color[15:8];
    assign O_single_b     = r_live_color[7:0];
    assign O_irq          = r_irq;

endmodule

// File: tb/tb_video_ctrl_wb.sv
// Self-checking bench for video_ctrl_wb: randomized bus traffic and vsync frames checked against a
// transaction-level model of the register file.
module tb_video_ctrl_wb;

    localparam int CF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
    logic [31:0] rdat;
    logic        ack;
    logic        vs = 1'b0;
    logic [1:0]  pmode;
    logic [7:0]  col_r, col_g, col_b;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    video_ctrl_wb #(.CYCLE_FRAMES(CF)) dut (
        .I_clk(clk), .I_rst(rst),
        .I_wb_adr(adr), .I_wb_dat(wdat), .I_wb_sel(sel), .I_wb_we(we),
        .I_wb_stb(stb), .I_wb_cyc(cyc),
        .O_wb_dat(rdat), .O_wb_ack(ack),
        .I_vs(vs),
        .O_pattern_mode(pmode), .O_single_r(col_r), .O_single_g(col_g), .O_single_b(col_b),
        .O_irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model state (register-map level).
    logic [1:0]  m_shadow_mode, m_live_mode;
    logic [23:0] m_shadow_col, m_live_col;
    logic        m_pending, m_sts, m_en, m_auto;
    logic [15:0] m_cnt;
    int          m_step;

    function automatic void model_reset();
        m_shadow_mode = 2'd0; m_live_mode = 2'd0;
        m_shadow_col = 24'h00FF00; m_live_col = 24'h00FF00;
        m_pending = 1'b0; m_sts = 1'b0; m_en = 1'b0; m_auto = 1'b0;
        m_cnt = 16'd0; m_step = 0;
    endfunction

    function automatic void model_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a == 2'd0) begin
            if (s[0]) begin
                m_shadow_mode = d[1:0];
`ifdef VIDEO_CTRL_AUTOCYCLE_EN
                m_auto = d[4];
                if (!m_auto) m_step = 0;
`endif
            end
            if (s != 4'd0) m_pending = 1'b1;
        end else if (a == 2'd1) begin
            for (int b = 0; b < 3; b++)
                if (s[b]) m_shadow_col[b*8 +: 8] = d[b*8 +: 8];
            if (s != 4'd0) m_pending = 1'b1;
        end else if (a == 2'd3) begin
            if (s[0] && d[0]) m_sts = 1'b0;
            if (s[1]) m_en = d[8];
        end
    endfunction

    function automatic void model_tick();
        m_cnt = m_cnt + 16'd1;
        m_sts = 1'b1;
        if (m_pending) begin
            m_live_mode = m_shadow_mode;
            m_live_col = m_shadow_col;
            m_pending = 1'b0;
            m_step = 0;
        end else if (m_auto) begin
            m_step++;
            if (m_step == CF) begin
                m_live_mode = m_live_mode + 2'd1;
                m_shadow_mode = m_live_mode;
                m_step = 0;
            end
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            2'd0: begin v[1:0] = m_shadow_mode; v[4] = m_auto; end
            2'd1: v[23:0] = m_shadow_col;
            2'd2: begin v[15:0] = m_cnt; v[16] = m_pending; v[18:17] = m_live_mode; end
            default: begin v[0] = m_sts; v[8] = m_en; end
        endcase
        return v;
    endfunction

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        model_write(a, d, s);
        n_checks++;
        if (ack !== 1'b1) begin
            n_errors++; $display("FAIL wr_ack adr=%0d: got %b expected 1", a, ack);
        end
        @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 1'b0 || irq !== (m_sts & m_en)) begin
            n_errors++; $display("FAIL wr_after: got ack=%b irq=%b expected ack=0 irq=%b", ack, irq, m_sts & m_en);
        end
        @(negedge clk);
    endtask

    task automatic wb_read(input logic [1:0] a);
        logic [31:0] exp;
        exp = model_read(a);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 1'b1 || rdat !== exp) begin
            n_errors++; $display("FAIL rd adr=%0d: got ack=%b dat=%h expected ack=1 dat=%h", a, ack, rdat, exp);
        end
        @(negedge clk); cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 1'b0 || rdat !== 32'd0) begin
            n_errors++; $display("FAIL rd_idle: got ack=%b dat=%h expected ack=0 dat=0", ack, rdat);
        end
        @(negedge clk);
    endtask

    // One vsync pulse; optionally a write whose request lands on the tick cycle.
    task automatic tick_frame(input bit with_wr, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        vs = 1'b1;
        repeat (5) @(negedge clk);
        vs = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (pmode !== m_live_mode || {col_r, col_g, col_b} !== m_live_col) begin
            n_errors++; $display("FAIL pre_tick: got mode=%0d col=%h expected mode=%0d col=%h", pmode, {col_r, col_g, col_b}, m_live_mode, m_live_col);
        end
        if (with_wr) begin
            @(negedge clk);
            cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
        end
        @(posedge clk); #1;
        model_tick();
        if (with_wr) begin
            model_write(a, d, s);
            m_sts = 1'b1;
            n_checks++;
            if (ack !== 1'b1) begin
                n_errors++; $display("FAIL tick_wr_ack: got %b expected 1", ack);
            end
        end
        n_checks++;
        if (pmode !== m_live_mode || {col_r, col_g, col_b} !== m_live_col) begin
            n_errors++; $display("FAIL tick_commit: got mode=%0d col=%h expected mode=%0d col=%h", pmode, {col_r, col_g, col_b}, m_live_mode, m_live_col);
        end
        @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (irq !== (m_sts & m_en)) begin
            n_errors++; $display("FAIL tick_irq: got %b expected %b", irq, m_sts & m_en);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; vs = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (ack !== 1'b0 || rdat !== 32'd0 || irq !== 1'b0 || pmode !== 2'd0 ||
            col_r !== 8'h00 || col_g !== 8'hFF || col_b !== 8'h00) begin
            n_errors++; $display("FAIL reset_outputs: got ack=%b dat=%h irq=%b mode=%0d rgb=%h%h%h expected 0,0,0,0,00FF00",
                                 ack, rdat, irq, pmode, col_r, col_g, col_b);
        end
        for (int i = 0; i < 4; i++) wb_read(2'(i));
    endtask

    task automatic test_commit();
        wb_write(2'd0, 32'd2, 4'hF);
        wb_read(2'd2);
        tick_frame(1'b0, 2'd0, 32'd0, 4'd0);
        n_checks++;
        if (pmode !== 2'd2) begin
            n_errors++; $display("FAIL commit_mode: got %0d expected 2", pmode);
        end
        wb_read(2'd2);
    endtask

    task automatic test_color_lanes();
        wb_write(2'd1, 32'h00123456, 4'b0010);
        wb_read(2'd1);
        tick_frame(1'b0, 2'd0, 32'd0, 4'd0);
        n_checks++;
        if (col_r !== 8'h00 || col_g !== 8'h34 || col_b !== 8'h00) begin
            n_errors++; $display("FAIL color_lane: got %h%h%h expected 003400", col_r, col_g, col_b);
        end
        wb_read(2'd1);
    endtask

    task automatic test_irq();
        wb_write(2'd3, 32'h100, 4'b0010);
        repeat (3) tick_frame(1'b0, 2'd0, 32'd0, 4'd0);
        wb_read(2'd2);
        n_checks++;
        if (irq !== 1'b1) begin
            n_errors++; $display("FAIL irq_level: got %b expected 1", irq);
        end
        tick_frame(1'b1, 2'd3, 32'h101, 4'b0011);
        wb_read(2'd3);
        wb_write(2'd3, 32'h101, 4'b0011);
        wb_read(2'd3);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        m_cnt = 16'hFFFF;
        wb_read(2'd2);
        tick_frame(1'b1, 2'd0, 32'd3, 4'b0001);
        wb_read(2'd2);
        tick_frame(1'b0, 2'd0, 32'd0, 4'd0);
        n_checks++;
        if (pmode !== 2'd3) begin
            n_errors++; $display("FAIL wrap_commit: got %0d expected 3", pmode);
        end
        wb_read(2'd2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        exp = model_read(2'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd1; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ack !== ((i % 2) == 0) || rdat !== (((i % 2) == 0) ? exp : 32'd0)) begin
                n_errors++; $display("FAIL b2b cycle %0d: got ack=%b dat=%h expected ack=%b", i, ack, rdat, (i % 2) == 0);
            end
        end
        @(negedge clk); cyc = 1'b0; stb = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd0; wdat = 32'd1; sel = 4'hF;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 1'b1) begin
            n_errors++; $display("FAIL mid_ack: got %b expected 1", ack);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        n_checks++;
        if (ack !== 1'b0 || irq !== 1'b0 || pmode !== 2'd0 || {col_r, col_g, col_b} !== 24'h00FF00) begin
            n_errors++; $display("FAIL mid_reset: got ack=%b irq=%b mode=%0d col=%h expected 0,0,0,00FF00",
                                 ack, irq, pmode, {col_r, col_g, col_b});
        end
        @(negedge clk); rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); @(negedge clk);
        wb_read(2'd0);
        wb_read(2'd2);
    endtask

    task automatic test_random();
        logic [1:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        for (int i = 0; i < 40; i++) begin
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom);
            case ($urandom_range(0, 3))
                0: wb_write(a, d, s);
                1: wb_read(a);
                2: tick_frame(1'b0, 2'd0, 32'd0, 4'd0);
                default: tick_frame(1'b1, a, d, s);
            endcase
        end
        for (int i = 0; i < 4; i++) wb_read(2'(i));
    endtask

`ifdef VIDEO_CTRL_AUTOCYCLE_EN
    task automatic test_autocycle();
        logic [1:0] seq [5];
        int k;
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        wb_write(2'd0, 32'h10, 4'b0001);
        tick_frame(1'b0, 2'd0, 32'd0, 4'd0);
        k = 0;
        for (int t = 1; t <= 8; t++) begin
            tick_frame(1'b0, 2'd0, 32'd0, 4'd0);
            if ((t % CF) == 0) begin
                k++;
                n_checks++;
                if (pmode !== seq[k]) begin
                    n_errors++; $display("FAIL autocycle step %0d: got %0d expected %0d", k, pmode, seq[k]);
                end
            end
        end
        wb_read(2'd0);
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_commit();
        test_color_lanes();
        test_irq();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef VIDEO_CTRL_AUTOCYCLE_EN
        test_autocycle();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
